// File: rtl/alu_exec.sv
// Execute-stage ALU: add/sub/and/or/xor/slt/sll/srl with result, zero and overflow flags.
// Latency: 1 cycle for all ops; sll/srl take 1+shamt cycles unless ALU_FAST_SHIFT_EN is defined.
// Backpressure: result is held in DONE until out_ready; a new op is accepted on the retiring edge.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     operation handshake (alu_cntrl, src_a, src_b sampled on accept)
//   out_valid/out_ready   result handshake (result, zero, overflow)
// Build option: ALU_FAST_SHIFT_EN selects a one-cycle barrel shifter. Without it,
// shifts run iteratively in a SHIFT state.
module alu_exec #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         alu_cntrl,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               overflow
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;

`ifdef ALU_FAST_SHIFT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
`endif

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  // Holds in_ready low while in reset and releases it on the first edge after.
  logic               ready_en_q, ready_en_d;

  logic [WIDTH-1:0]   sum, diff, op_res;
  logic               op_ovf;
  logic [SHAMT_W-1:0] shamt;
  logic               accept;

`ifndef ALU_FAST_SHIFT_EN
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               shr_q, shr_d;
  logic [WIDTH-1:0]   acc_step;
`endif

  assign shamt     = src_b[SHAMT_W-1:0];
  assign in_ready  = ready_en_q && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;

  // Operation datapath on the live inputs; only consumed on an accept edge.
  always_comb begin
    sum    = src_a + src_b;
    diff   = src_a - src_b;
    op_res = '0;
    op_ovf = 1'b0;
    case (alu_cntrl)
      OP_ADD: begin
        op_res = sum;
        op_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
      end
      OP_SUB: begin
        op_res = diff;
        op_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);
      end
      OP_AND:  op_res = src_a & src_b;
      OP_OR:   op_res = src_a | src_b;
      OP_XOR:  op_res = src_a ^ src_b;
      OP_SLT:  op_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
`ifdef ALU_FAST_SHIFT_EN
      OP_SLL:  op_res = src_a << shamt;
      OP_SRL:  op_res = src_a >> shamt;
`else
      // Iterative build: only the shamt==0 case finishes here.
      OP_SLL:  op_res = src_a;
      OP_SRL:  op_res = src_a;
`endif
      default: op_res = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    zero_d     = zero_q;
    ovf_d      = ovf_q;
    ready_en_d = 1'b1;
`ifndef ALU_FAST_SHIFT_EN
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    shr_d      = shr_q;
    acc_step   = shr_q ? (acc_q >> 1) : (acc_q << 1);
`endif

    case (state_q)
      DONE: if (out_ready) state_d = IDLE;
`ifndef ALU_FAST_SHIFT_EN
      SHIFT: begin
        acc_d = acc_step;
        cnt_d = cnt_q - SHAMT_W'(1);
        // Final step registers the shifted value directly so latency is 1+shamt.
        if (cnt_q == SHAMT_W'(1)) begin
          result_d = acc_step;
          zero_d   = (acc_step == '0);
          ovf_d    = 1'b0;
          state_d  = DONE;
        end
      end
`endif
      default: ;
    endcase

    // Accept overrides the DONE->IDLE retire so back-to-back ops have no bubble.
    if (accept) begin
`ifndef ALU_FAST_SHIFT_EN
      if (alu_cntrl == OP_SLL || alu_cntrl == OP_SRL) begin
        acc_d = src_a;
        cnt_d = shamt;
        shr_d = (alu_cntrl == OP_SRL);
        if (shamt == '0) begin
          result_d = src_a;
          zero_d   = (src_a == '0);
          ovf_d    = 1'b0;
          state_d  = DONE;
        end else begin
          state_d  = SHIFT;
        end
      end else
`endif
      begin
        result_d = op_res;
        zero_d   = (op_res == '0);
        ovf_d    = op_ovf;
        state_d  = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      result_q   <= '0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      ready_en_q <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
      acc_q      <= '0;
      cnt_q      <= '0;
      shr_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      ovf_q      <= ovf_d;
      ready_en_q <= ready_en_d;
`ifndef ALU_FAST_SHIFT_EN
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      shr_q      <= shr_d;
`endif
    end
  end

endmodule
